// File: rtl/seg_share_ctrl.sv
// Two-requester, round-robin write controller for an 8-digit seven-segment bank.
// Digit state feeds a hex decoder and blink gate into registered active-low outputs.
module seg_share_ctrl #(
    parameter int BLINK_DIV   = 25000000,
    parameter bit RESET_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_idx,
    input  logic [3:0] a_val,
    input  logic       a_dp,
    input  logic       a_blank,
    input  logic       a_blink,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [2:0] b_idx,
    input  logic [3:0] b_val,
    input  logic       b_dp,
    input  logic       b_blank,
    input  logic       b_blink,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    localparam int            CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic          PTR_A    = 1'b0;
    localparam logic          PTR_B    = 1'b1;
    localparam logic [7:0]    SEG_RST  = RESET_BLANK ? 8'hFF : 8'h03;

    logic [7:0][3:0] val_q, val_d;
    logic [7:0]      dp_q, dp_d;
    logic [7:0]      blank_q, blank_d;
    logic [7:0]      blink_q, blink_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [7:0][7:0] seg_q, seg_d;

    // Active-high a..g in bits 7..1; bit 0 (dp) is left clear.
    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hFC;  4'h1: hex7 = 8'h60;
            4'h2: hex7 = 8'hDA;  4'h3: hex7 = 8'hF2;
            4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'hB6;
            4'h6: hex7 = 8'hBE;  4'h7: hex7 = 8'hE0;
            4'h8: hex7 = 8'hFE;  4'h9: hex7 = 8'hF6;
            4'hA: hex7 = 8'hEE;  4'hB: hex7 = 8'h3E;
            4'hC: hex7 = 8'h9C;  4'hD: hex7 = 8'h7A;
            4'hE: hex7 = 8'h9E;  default: hex7 = 8'h8E;
        endcase
    endfunction

    // A lone requester always wins; on contention the pointer decides.
    assign a_ready = !clr && a_valid && (!b_valid || ptr_q == PTR_A);
    assign b_ready = !clr && b_valid && (!a_valid || ptr_q == PTR_B);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        val_d   = val_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        blink_d = blink_q;
        ptr_d   = ptr_q;
        if (clr) begin
            val_d   = '0;
            dp_d    = '0;
            blank_d = '1;
            blink_d = '0;
        end else if (a_ready) begin
            val_d[a_idx]   = a_val;
            dp_d[a_idx]    = a_dp;
            blank_d[a_idx] = a_blank;
            blink_d[a_idx] = a_blink;
            ptr_d          = PTR_B;
        end else if (b_ready) begin
            val_d[b_idx]   = b_val;
            dp_d[b_idx]    = b_dp;
            blank_d[b_idx] = b_blank;
            blink_d[b_idx] = b_blink;
            ptr_d          = PTR_A;
        end
    end

    always_comb begin
        logic [7:0] pat;
        pat     = '0;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        phase_d = phase_q ^ (cnt_q == CNT_LAST);
        for (int i = 0; i < 8; i++) begin
            pat = blank_q[i] ? 8'h00 : (hex7(val_q[i]) | {7'b0, dp_q[i]});
            if (blink_q[i] && !phase_q) pat = 8'h00;
            seg_d[i] = ~pat;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the digit file is
    // eight flops wide, so it is reset like any other register rather than as a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q   <= '0;
            dp_q    <= '0;
            blank_q <= {8{RESET_BLANK}};
            blink_q <= '0;
            ptr_q   <= PTR_A;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            seg_q   <= {8{SEG_RST}};
        end else begin
            val_q   <= val_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            blink_q <= blink_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign o_seg0 = seg_q[0];
    assign o_seg1 = seg_q[1];
    assign o_seg2 = seg_q[2];
    assign o_seg3 = seg_q[3];
    assign o_seg4 = seg_q[4];
    assign o_seg5 = seg_q[5];
    assign o_seg6 = seg_q[6];
    assign o_seg7 = seg_q[7];

endmodule
